// File: rtl/jk_pkg.sv
// Shared definitions for the j/k OFF/ON control interface.
// Used by the pattern driver, the OFF/ON receiver and their benches.
package jk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_DONE
  } jk_state_e;

  localparam logic LVL_OFF = 1'b0;
  localparam logic LVL_ON  = 1'b1;

endpackage

// File: rtl/jk_slot_timer.sv
// Per-slot down-counter for the j/k pattern driver.
// Reloads on load; last flags the final cycle of a slot.
module jk_slot_timer #(
  parameter int HOLD_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [HOLD_W-1:0] load_val,
  input  logic              tick,
  output logic              last
);

  logic [HOLD_W-1:0] cnt_q;
  logic [HOLD_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (tick && cnt_q != '0) begin
      cnt_d = cnt_q - HOLD_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last = (cnt_q == '0);

endmodule

// File: rtl/jk_pattern_driver.sv
// Replays an on/off pattern as j/k pulses into an OFF/ON machine,
// shadowing the downstream level and checking its feedback.
module jk_pattern_driver
  import jk_pkg::*;
#(
  parameter int PAT_W  = 8,
  parameter int HOLD_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pat_valid,
  output logic              pat_ready,
  input  logic [PAT_W-1:0]  pat_data,
  input  logic [HOLD_W-1:0] pat_hold,
  output logic              j,
  output logic              k,
  output logic              expect_out,
  input  logic              fb_out,
  input  logic              check_en,
  output logic              busy,
  output logic              done,
  output logic              mismatch
);

  localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;

  jk_state_e         state_q, state_d;
  logic [PAT_W-1:0]  pat_q, pat_d;
  logic [HOLD_W-1:0] hm1_q, hm1_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              first_q, first_d;
  logic              exp_q, exp_d;
  logic              j_q, j_d;
  logic              k_q, k_d;
  logic              mm_q, mm_d;

  logic              accept;
  logic              drive;
  logic              last_idx;
  logic              cur_b;
  logic              nxt_b;
  logic              exp_nxt;
  logic [IDX_W-1:0]  idx_nxt;
  logic [HOLD_W-1:0] hold_m1;
  logic              tmr_load;
  logic [HOLD_W-1:0] tmr_val;
  logic              tmr_last;

  assign pat_ready = (state_q == ST_IDLE) && !reset;
  assign accept    = pat_valid && pat_ready;
  assign drive     = (state_q == ST_DRIVE);
  assign last_idx  = (idx_q == IDX_W'(PAT_W - 1));
  assign idx_nxt   = idx_q + IDX_W'(1);
  assign cur_b     = pat_q[idx_q];
  assign nxt_b     = pat_q[idx_nxt];
  assign hold_m1   = (pat_hold == '0) ? '0 : pat_hold - HOLD_W'(1);
  assign tmr_load  = accept || (drive && tmr_last);
  assign tmr_val   = accept ? hold_m1 : hm1_q;

  // Level the shadow will hold after this edge; pulses for the
  // next slot are decided against it, not the current one.
  assign exp_nxt = (drive && first_q) ? cur_b : exp_q;

  jk_slot_timer #(
    .HOLD_W(HOLD_W)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .load    (tmr_load),
    .load_val(tmr_val),
    .tick    (drive),
    .last    (tmr_last)
  );

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    hm1_d   = hm1_q;
    idx_d   = idx_q;
    first_d = 1'b0;
    exp_d   = exp_nxt;
    j_d     = 1'b0;
    k_d     = 1'b0;
    mm_d    = mm_q;
    if (drive && check_en && (fb_out != exp_q)) begin
      mm_d = 1'b1;
    end
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_DRIVE;
          pat_d   = pat_data;
          hm1_d   = hold_m1;
          idx_d   = '0;
          first_d = 1'b1;
          mm_d    = 1'b0;
          j_d     = pat_data[0] & ~exp_q;
          k_d     = ~pat_data[0] & exp_q;
        end
      end
      ST_DRIVE: begin
        if (tmr_last) begin
          if (last_idx) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_nxt;
            first_d = 1'b1;
            j_d     = nxt_b & ~exp_nxt;
            k_d     = ~nxt_b & exp_nxt;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pat_q   <= '0;
      hm1_q   <= '0;
      idx_q   <= '0;
      first_q <= 1'b0;
      exp_q   <= LVL_OFF;
      j_q     <= 1'b0;
      k_q     <= 1'b0;
      mm_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      hm1_q   <= hm1_d;
      idx_q   <= idx_d;
      first_q <= first_d;
      exp_q   <= exp_d;
      j_q     <= j_d;
      k_q     <= k_d;
      mm_q    <= mm_d;
    end
  end

  assign j          = j_q;
  assign k          = k_q;
  assign expect_out = exp_q;
  assign busy       = drive;
  assign done       = (state_q == ST_DONE);
  assign mismatch   = mm_q;

endmodule

// File: tb/tb_jk_pattern_driver.sv
// Bench for jk_pattern_driver driving a behavioural OFF/ON machine.
// Expected cycles come from a slot-by-slot model of the pattern rules.
module tb_jk_pattern_driver;

  logic       clk = 1'b0;
  logic       reset;
  logic       pat_valid;
  logic       pat_ready;
  logic [7:0] pat_data;
  logic [3:0] pat_hold;
  logic       j, k, expect_out;
  logic       fb_out, check_en;
  logic       busy, done, mismatch;
  logic       ds_out;
  logic       fb_force;

  int pass_n = 0;
  int tot_n  = 0;
  bit lvl_m  = 1'b0;

  typedef struct {
    logic [7:0] pat;
    logic [3:0] hold;
    bit         frc;
    int         ej;
    int         ek;
    int         eb;
  } vec_t;

  vec_t vecs[6];

  always #5 clk = ~clk;

  jk_pattern_driver dut (
    .clk       (clk),
    .reset     (reset),
    .pat_valid (pat_valid),
    .pat_ready (pat_ready),
    .pat_data  (pat_data),
    .pat_hold  (pat_hold),
    .j         (j),
    .k         (k),
    .expect_out(expect_out),
    .fb_out    (fb_out),
    .check_en  (check_en),
    .busy      (busy),
    .done      (done),
    .mismatch  (mismatch)
  );

  // Downstream OFF/ON Moore machine
  always_ff @(posedge clk) begin
    if (reset) ds_out <= 1'b0;
    else if (!ds_out && j) ds_out <= 1'b1;
    else if (ds_out && k) ds_out <= 1'b0;
  end

  assign fb_out = fb_force ? 1'b0 : ds_out;

  task automatic chk(input string nm, input int act, input int exp);
    tot_n++;
    if (act == exp) pass_n++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  function automatic int bundle();
    return {25'd0, j, k, expect_out, busy, done, pat_ready, mismatch};
  endfunction

  function automatic int mk(bit a, bit b, bit c, bit d,
                            bit e, bit f, bit g);
    return {25'd0, a, b, c, d, e, f, g};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_pat(input logic [7:0] p, input logic [3:0] h,
                         input bit frc, output int jc, output int kc,
                         output int bc);
    int  hh, n, slot;
    bit  first, b, ej, ek, mm;
    hh = (h == 0) ? 1 : int'(h);
    n  = 8 * hh;
    jc = 0; kc = 0; bc = 0; mm = 1'b0;
    chk("ready_before_accept", pat_ready, 1);
    pat_valid = 1'b1;
    pat_data  = p;
    pat_hold  = h;
    step();
    pat_valid = 1'b0;
    pat_data  = ~p;
    pat_hold  = 4'd7;
    fb_force  = frc;
    for (int c = 0; c < n; c++) begin
      slot  = c / hh;
      first = (c % hh) == 0;
      b     = p[slot];
      ej    = first && b && !lvl_m;
      ek    = first && !b && lvl_m;
      chk("busy_cycle", bundle(), mk(ej, ek, lvl_m, 1, 0, 0, mm));
      if (!frc) chk("ds_out", ds_out, lvl_m);
      jc += int'(j);
      kc += int'(k);
      bc += int'(busy);
      if (check_en && ((frc ? 1'b0 : lvl_m) != lvl_m)) mm = 1'b1;
      if (first) lvl_m = b;
      step();
    end
    chk("done_cycle", bundle(), mk(0, 0, lvl_m, 0, 1, 0, mm));
    step();
    chk("idle_after", bundle(), mk(0, 0, lvl_m, 0, 0, 1, mm));
    fb_force = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while (!done && n < 200) begin
      if (busy) chk("no_accept_busy", pat_ready, 0);
      step();
      n++;
    end
    chk(nm, done, 1);
  endtask

  initial begin
    int jc, kc, bc;
    vecs[0] = '{8'h05, 4'd1, 1'b0, 2, 2, 8};
    vecs[1] = '{8'hFF, 4'd3, 1'b0, 1, 0, 24};
    vecs[2] = '{8'hFF, 4'd3, 1'b0, 0, 0, 24};
    vecs[3] = '{8'hA5, 4'd0, 1'b0, 3, 3, 8};
    vecs[4] = '{8'h01, 4'd1, 1'b1, 0, 1, 8};
    vecs[5] = '{8'h00, 4'd2, 1'b0, 0, 0, 16};

    reset     = 1'b1;
    pat_valid = 1'b0;
    pat_data  = '0;
    pat_hold  = '0;
    check_en  = 1'b1;
    fb_force  = 1'b0;
    step();
    chk("ready_in_reset", pat_ready, 0);
    step();
    reset = 1'b0;
    #1;
    chk("reset_state", bundle(), mk(0, 0, 0, 0, 0, 1, 0));
    lvl_m = 1'b0;

    foreach (vecs[i]) begin
      run_pat(vecs[i].pat, vecs[i].hold, vecs[i].frc, jc, kc, bc);
      chk("vec_j_count", jc, vecs[i].ej);
      chk("vec_k_count", kc, vecs[i].ek);
      chk("vec_busy_len", bc, vecs[i].eb);
    end

    // Back-to-back with pat_valid held high
    pat_valid = 1'b1;
    pat_data  = 8'hC3;
    pat_hold  = 4'd1;
    step();
    chk("b2b_busy1", busy, 1);
    wait_done("b2b_done1");
    step();
    chk("b2b_idle_gap", {busy, pat_ready}, 2'b01);
    step();
    chk("b2b_busy2", busy, 1);
    wait_done("b2b_done2");
    pat_valid = 1'b0;
    step();
    chk("b2b_idle_end", {busy, pat_ready}, 2'b01);
    lvl_m = 1'b1;

    // Reset in slot 4 of 0xF0
    pat_valid = 1'b1;
    pat_data  = 8'hF0;
    pat_hold  = 4'd1;
    step();
    pat_valid = 1'b0;
    repeat (4) step();
    chk("slot4_j", {j, k, busy}, 3'b101);
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    chk("mid_reset", bundle(), mk(0, 0, 0, 0, 0, 1, 0));
    chk("mid_reset_ds", ds_out, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("no_done_after_rst", {done, busy}, 0);
    end
    lvl_m = 1'b0;

    for (int r = 0; r < 20; r++) begin
      run_pat(8'($urandom), 4'($urandom_range(0, 3)),
              $urandom_range(0, 3) == 0, jc, kc, bc);
    end

    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end

endmodule
